// File: rtl/collatz_seq_core.sv
//==============================================================================
// Module      : collatz_seq_core
// Description : Collatz sequence engine with an ap_ctrl_hs block handshake.
//               From an accepted start value it iterates n -> n/2 (even) or
//               n -> 3n+1 (odd), one step per clock, until n == 1. It then
//               reports the step count and the peak value reached.
//               Zero input, 3n+1 overflow and the step limit abort the run
//               early and set the matching error flag.
// Ports       : ap_clk     - clock, rising edge
//               ap_rst     - asynchronous active-high reset
//               ap_start   - start request, held by the driver until ap_ready
//               n_in       - start value, sampled when ap_ready = 1
//               ap_ready   - input consumed this cycle
//               ap_idle    - core is idle
//               ap_done    - one-cycle pulse, results valid
//               steps_out  - steps taken to reach 1, or to the abort point
//               peak_out   - largest value seen, start value included
//               err_zero   - start value was 0
//               err_ovf    - 3n+1 did not fit in DATA_W bits
//               err_tmo    - MAX_STEPS reached before n == 1
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module collatz_seq_core #(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1000   // must be < 2**CNT_W
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    input  logic [DATA_W-1:0] n_in,
    output logic              ap_ready,
    output logic              ap_idle,
    output logic              ap_done,
    output logic [CNT_W-1:0]  steps_out,
    output logic [DATA_W-1:0] peak_out,
    output logic              err_zero,
    output logic              err_ovf,
    output logic              err_tmo
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_MAX_STEPS = CNT_W'(MAX_STEPS);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_cur;
    logic [DATA_W-1:0] r_peak;
    logic [CNT_W-1:0]  r_steps;
    logic              r_done;
    logic              r_err_zero;
    logic              r_err_ovf;
    logic              r_err_tmo;

    // 3n+1 carried two bits wider than the working register so that any
    // result that does not fit in DATA_W bits is visible in the top bits.
    logic [DATA_W+1:0] w_triple;
    logic              w_triple_ovf;

    assign w_triple     = ({2'b00, r_cur} << 1) + {2'b00, r_cur} + (DATA_W+2)'(1);
    assign w_triple_ovf = |w_triple[DATA_W+1:DATA_W];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state    <= c_IDLE;
            r_cur      <= '0;
            r_peak     <= '0;
            r_steps    <= '0;
            r_done     <= 1'b0;
            r_err_zero <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_tmo  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (ap_start) begin
                        r_cur      <= n_in;
                        r_peak     <= n_in;
                        r_steps    <= '0;
                        r_err_ovf  <= 1'b0;
                        r_err_tmo  <= 1'b0;
                        if (n_in == '0) begin
                            // Zero never reaches 1; report it immediately.
                            r_err_zero <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= c_DONE;
                        end else begin
                            r_err_zero <= 1'b0;
                            r_state    <= c_CALC;
                        end
                    end
                end

                c_CALC: begin
                    // Termination is tested before the step limit so that a
                    // run reaching 1 on exactly MAX_STEPS steps is not an error.
                    if (r_cur == DATA_W'(1)) begin
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end else if (r_steps == c_MAX_STEPS) begin
                        r_err_tmo <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= c_DONE;
                    end else if (!r_cur[0]) begin
                        r_cur   <= r_cur >> 1;
                        r_steps <= r_steps + CNT_W'(1);
                    end else if (w_triple_ovf) begin
                        // Abort without committing the failed step.
                        r_err_ovf <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= c_DONE;
                    end else begin
                        r_cur   <= w_triple[DATA_W-1:0];
                        r_steps <= r_steps + CNT_W'(1);
                        if (w_triple[DATA_W-1:0] > r_peak) begin
                            r_peak <= w_triple[DATA_W-1:0];
                        end
                    end
                end

                c_DONE: begin
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Ready is combinational on start so a held request is taken in the
    // very first idle cycle, including the one right after DONE.
    assign ap_ready  = (r_state == c_IDLE) & ap_start;
    assign ap_idle   = (r_state == c_IDLE);
    assign ap_done   = r_done;
    assign steps_out = r_steps;
    assign peak_out  = r_peak;
    assign err_zero  = r_err_zero;
    assign err_ovf   = r_err_ovf;
    assign err_tmo   = r_err_tmo;

endmodule

`default_nettype wire

// File: tb/tb_collatz_seq_core.sv
//==============================================================================
// Module      : tb_collatz_seq_core
// Description : Self-checking bench for collatz_seq_core. Three instances
//               share clock and reset: default parameters, DATA_W = 8, and
//               MAX_STEPS = 50. Results are compared against a plain
//               arithmetic Collatz model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_collatz_seq_core;

    logic ap_clk;
    logic ap_rst;

    logic [2:0]  r_start;
    logic [31:0] r_nin [3];

    logic [2:0]  w_rdy, w_idl, w_dn, w_ez, w_eo, w_et;
    logic [15:0] w_st0, w_st1, w_st2;
    logic [31:0] w_pk0, w_pk2;
    logic [7:0]  w_pk1;

    int n_tests = 0;
    int n_fail  = 0;

    collatz_seq_core u_dut_def (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(r_start[0]), .n_in(r_nin[0]),
        .ap_ready(w_rdy[0]), .ap_idle(w_idl[0]), .ap_done(w_dn[0]),
        .steps_out(w_st0), .peak_out(w_pk0),
        .err_zero(w_ez[0]), .err_ovf(w_eo[0]), .err_tmo(w_et[0])
    );

    collatz_seq_core #(.DATA_W(8)) u_dut_w8 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(r_start[1]), .n_in(r_nin[1][7:0]),
        .ap_ready(w_rdy[1]), .ap_idle(w_idl[1]), .ap_done(w_dn[1]),
        .steps_out(w_st1), .peak_out(w_pk1),
        .err_zero(w_ez[1]), .err_ovf(w_eo[1]), .err_tmo(w_et[1])
    );

    collatz_seq_core #(.MAX_STEPS(50)) u_dut_m50 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(r_start[2]), .n_in(r_nin[2]),
        .ap_ready(w_rdy[2]), .ap_idle(w_idl[2]), .ap_done(w_dn[2]),
        .steps_out(w_st2), .peak_out(w_pk2),
        .err_zero(w_ez[2]), .err_ovf(w_eo[2]), .err_tmo(w_et[2])
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    function automatic longint get_steps(input int idx);
        if (idx == 0) return longint'(w_st0);
        if (idx == 1) return longint'(w_st1);
        return longint'(w_st2);
    endfunction

    function automatic longint get_peak(input int idx);
        if (idx == 0) return longint'(w_pk0);
        if (idx == 1) return longint'(w_pk1);
        return longint'(w_pk2);
    endfunction

    function automatic int dw_of(input int idx);
        return (idx == 1) ? 8 : 32;
    endfunction

    function automatic int ms_of(input int idx);
        return (idx == 2) ? 50 : 1000;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: the Collatz rules applied directly with wide integers.
    task automatic model(input longint n, input int dw, input int ms,
                         output longint steps, output longint peak,
                         output bit ez, output bit eo, output bit et,
                         output int lat);
        longint cur;
        longint t;
        steps = 0; peak = n; ez = 0; eo = 0; et = 0;
        if (n == 0) begin
            ez  = 1;
            lat = 1;
            return;
        end
        cur = n;
        while (cur != 1) begin
            if (steps == ms) begin
                et = 1;
                break;
            end
            if (cur % 2 == 0) begin
                cur = cur / 2;
            end else begin
                t = 3 * cur + 1;
                if (t >= (longint'(1) << dw)) begin
                    eo = 1;
                    break;
                end
                cur = t;
                if (t > peak) peak = t;
            end
            steps++;
        end
        lat = 2 + int'(steps);
    endtask

    // One transaction on instance idx. With hold set, ap_start stays high
    // after ap_done and n_in is switched to n_next for a back-to-back start.
    task automatic run_txn(input int idx, input longint n, input bit hold, input longint n_next);
        longint st_e, pk_e;
        bit ez, eo, et;
        int lat;
        int c;
        bit seen;
        string pfx;
        pfx = $sformatf("d%0d n=%0d", idx, n);
        model(n, dw_of(idx), ms_of(idx), st_e, pk_e, ez, eo, et, lat);

        @(negedge ap_clk);
        r_start[idx] = 1'b1;
        r_nin[idx]   = n[31:0];
        #1;
        chk({pfx, " ready_on"}, longint'(w_rdy[idx]), 1);

        @(negedge ap_clk);
        chk({pfx, " ready_off"}, longint'(w_rdy[idx]), 0);
        chk({pfx, " idle_off"}, longint'(w_idl[idx]), 0);
        if (!hold) r_start[idx] = 1'b0;

        seen = 1'b0;
        for (c = 1; c <= 1100; c++) begin
            if (c > 1) @(negedge ap_clk);
            if (w_dn[idx]) begin
                seen = 1'b1;
                break;
            end
        end
        chk({pfx, " done_seen"}, longint'(seen), 1);
        if (seen) chk({pfx, " latency"}, longint'(c), longint'(lat));
        chk({pfx, " steps"}, get_steps(idx), st_e);
        chk({pfx, " peak"}, get_peak(idx), pk_e);
        chk({pfx, " errs"}, longint'({w_ez[idx], w_eo[idx], w_et[idx]}),
            longint'({ez, eo, et}));

        if (hold) begin
            r_nin[idx] = n_next[31:0];
        end else begin
            @(negedge ap_clk);
            chk({pfx, " done_pulse"}, longint'(w_dn[idx]), 0);
            chk({pfx, " steps_held"}, get_steps(idx), st_e);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        longint n;
        int idx;
        bit quiet;

        ap_rst  = 1'b1;
        r_start = 3'b000;
        for (int i = 0; i < 3; i++) r_nin[i] = 32'd0;

        repeat (3) @(posedge ap_clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d rst_outs", i),
                get_steps(i) + get_peak(i) +
                longint'({w_dn[i], w_rdy[i], w_ez[i], w_eo[i], w_et[i]}), 0);
            chk($sformatf("d%0d rst_idle", i), longint'(w_idl[i]), 1);
        end
        @(negedge ap_clk);
        ap_rst = 1'b0;

        quiet = 1'b1;
        repeat (20) begin
            @(negedge ap_clk);
            if ({w_idl, w_dn, w_rdy} !== 9'b111_000_000) quiet = 1'b0;
        end
        chk("quiet_after_reset", longint'(quiet), 1);

        // Directed cases.
        run_txn(0, 6, 1'b0, 0);
        run_txn(0, 27, 1'b1, 1);
        run_txn(0, 1, 1'b0, 0);
        run_txn(0, 0, 1'b0, 0);
        run_txn(1, 27, 1'b0, 0);
        run_txn(2, 27, 1'b0, 0);
        run_txn(0, 97, 1'b0, 0);

        // Reset in the middle of a computation.
        @(negedge ap_clk);
        r_start[0] = 1'b1;
        r_nin[0]   = 32'd27;
        @(negedge ap_clk);
        r_start[0] = 1'b0;
        repeat (40) @(negedge ap_clk);
        ap_rst = 1'b1;
        #1;
        chk("midrst idle", longint'(w_idl[0]), 1);
        chk("midrst outs", get_steps(0) + get_peak(0) + longint'(w_dn[0]), 0);
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        quiet = 1'b1;
        repeat (120) begin
            @(negedge ap_clk);
            if (w_dn[0] !== 1'b0 || w_idl[0] !== 1'b1) quiet = 1'b0;
        end
        chk("midrst no_done", longint'(quiet), 1);
        run_txn(0, 7, 1'b0, 0);

        // Randomized cases across all three instances.
        for (int i = 0; i < 24; i++) begin
            idx = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) begin
                n = 0;
            end else if (idx == 0) begin
                n = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(1, 5000))
                                                : longint'($urandom());
            end else if (idx == 1) begin
                n = longint'($urandom_range(1, 255));
            end else begin
                n = longint'($urandom_range(1, 300));
            end
            run_txn(idx, n, 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/collatz_seq_core.md
Name: collatz_seq_core

Overview:
- Synthesizable Collatz sequence engine with an ap_ctrl_hs block-level handshake.
- Accepts a start value and iterates n -> n/2 (even) or 3n+1 (odd), one step per clock, until n == 1.
- Reports the step count and the peak value reached.
- Directly upstream of the dataflow status monitor: its ap_start/ap_ready/ap_done are the signals that monitor samples, with ap_continue tied high.

Parameters:
- DATA_W, 32, width of start value and working register.
- CNT_W, 16, width of step counter.
- MAX_STEPS, 1000, step limit before timeout abort; must be < 2^CNT_W.

Ports:
- ap_clk  input  1  clock, all state on rising edge.
- ap_rst  input  1  reset, asynchronous, active-high.
- ap_start  input  1  request; driver holds high until ap_ready.
- n_in  input  DATA_W  start value, sampled when ap_ready=1.
- ap_ready  output  1  input consumed this cycle.
- ap_idle  output  1  core in IDLE.
- ap_done  output  1  one-cycle pulse, results valid.
- steps_out  output  CNT_W  steps taken to reach 1 (or to abort point).
- peak_out  output  DATA_W  maximum value seen, start value included.
- err_zero  output  1  n_in was 0.
- err_ovf  output  1  3n+1 exceeded DATA_W.
- err_tmo  output  1  MAX_STEPS reached before n == 1.

Behaviour:
- Reset (async, any state): state=IDLE. ap_done=0, ap_ready=0, ap_idle=1, steps_out=0, peak_out=0, all err_* = 0. Working registers are cleared. An in-flight computation is discarded and produces no ap_done.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - ap_ready = ap_start (combinational). ap_idle=1.
  - On ap_start=1: latch cur=n_in, peak=n_in, steps=0, clear err_*, go to CALC.
  - If n_in==0: set err_zero and go directly to DONE.
- CALC (ap_idle=0, ap_ready=0), evaluated in this priority order each cycle:
  1. cur==1: go to DONE.
  2. steps==MAX_STEPS: set err_tmo, go to DONE.
  3. cur even: cur <= cur>>1, steps++.
  4. cur odd: compute 3*cur+1 at DATA_W+2 bits.
     - If the result is >= 2^DATA_W: set err_ovf, go to DONE. cur, steps and peak are left unchanged.
     - Otherwise: cur <= result, steps++, peak <= max(peak, result).
- DONE: for exactly one cycle, ap_done=1. steps_out, peak_out and err_* are driven from the registers and held stable until the next accepted start. Next state is IDLE.
- Latency:
  - Accept at cycle T; ap_done at T+2+k for k successful steps.
  - n_in=1 gives ap_done at T+2 with steps_out=0.
  - n_in=0 gives ap_done at T+1.
- Back-to-back: if ap_start is still high in the IDLE cycle after DONE, that cycle is accepted. No start is accepted in CALC or DONE.
- ap_start dropped while in CALC: computation continues unaffected.
- The counter never wraps; MAX_STEPS is enforced before any increment.

Test Plan:
- Reset held, then released, ap_start=0 -> ap_idle=1, ap_done=0, all outputs 0; no activity for 20 cycles.
- Start with n_in=6 -> ap_ready for 1 cycle at T; ap_done at T+10; steps_out=8, peak_out=16, err_*=0.
- Start with n_in=27 (defaults) -> steps_out=111, peak_out=9232, ap_done at T+113. Then n_in=1 back-to-back (ap_start held) -> accepted the cycle after DONE; steps_out=0, peak_out=1.
- Start with n_in=0 -> ap_done at T+1, err_zero=1, steps_out=0, peak_out=0.
- Boundaries:
  - DATA_W=8, n_in=27 -> err_ovf=1, steps_out=11, peak_out=214.
  - MAX_STEPS=50, n_in=27 -> err_tmo=1, steps_out=50.
- Assert ap_rst mid-CALC (n_in=27, step 40) -> immediately ap_idle=1, no ap_done pulse. A new start with n_in=7 then yields steps_out=16, peak_out=52.
